// File: rtl/ctrl_pkg.sv
// Shared types for the core control FSM: state encoding, instruction classes, fault codes.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_FWAIT = 3'd1,
        S_MEM   = 3'd2,
        S_MWAIT = 3'd3,
        S_EXEC  = 3'd4,
        S_TRAP  = 3'd5
    } state_t;

    localparam logic [3:0] INST_ALU     = 4'h0;
    localparam logic [3:0] INST_LOAD    = 4'h1;
    localparam logic [3:0] INST_STORE   = 4'h2;
    localparam logic [3:0] INST_BRANCH  = 4'h3;
    localparam logic [3:0] INST_ILLEGAL = 4'hF;

    localparam logic [1:0] FAULT_NONE    = 2'd0;
    localparam logic [1:0] FAULT_FETCH   = 2'd1;
    localparam logic [1:0] FAULT_MEM     = 2'd2;
    localparam logic [1:0] FAULT_ILLEGAL = 2'd3;

endpackage

// File: rtl/wait_timer.sv
// Per-state watchdog: counts enabled cycles, restarts on clear; MAX_WAIT=0 disables expiry.
module wait_timer #(
    parameter int MAX_WAIT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    logic [W-1:0] cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)      cnt <= '0;
        else if (clear)  cnt <= '0;
        else if (enable) cnt <= cnt + W'(1);
    end

    // Expires on the MAX_WAIT-th cycle in the state, so a state is held at most MAX_WAIT cycles.
    generate
        if (MAX_WAIT == 0) begin : g_off
            assign expired = 1'b0;
        end else begin : g_on
            assign expired = enable && (cnt == W'(MAX_WAIT - 1));
        end
    endgenerate

endmodule

// File: rtl/ctrl_fsm.sv
// Multicycle core control FSM with IFU/LSU valid-ready channels, watchdog and illegal trap.
// Define CTRL_PERF_CNT_EN to build the cycle/instret/stall perf counters.
module ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 255,
    parameter int CNT_W    = 32,
    parameter int TYPE_W   = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ifu_reqReady,
    input  logic              ifu_respValid,
    input  logic              lsu_reqReady,
    input  logic              lsu_respValid,
    input  logic [TYPE_W-1:0] inst_type,
    input  logic              fault_clear,
    output logic              ifu_reqValid,
    output logic              lsu_reqValid,
    output logic              lsu_wen,
    output logic              pc_wen,
    output logic              reg_wen,
    output logic              finished,
    output logic              fault,
    output logic [1:0]        fault_code,
    output logic [2:0]        state,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  instret_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    state_t     st_q, st_d;
    logic       is_store_q, is_store_d;
    logic [1:0] code_q, code_d;
    logic       wd_en, wd_exp;
    logic       ifu_rv, lsu_rv, lsu_w, pc_w, reg_w, fin, flt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            st_q       <= S_FETCH;
            is_store_q <= 1'b0;
            code_q     <= FAULT_NONE;
        end else begin
            st_q       <= st_d;
            is_store_q <= is_store_d;
            code_q     <= code_d;
        end
    end

    assign wd_en = (st_q == S_FETCH) || (st_q == S_FWAIT) ||
                   (st_q == S_MEM)   || (st_q == S_MWAIT);

    wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (st_d != st_q),
        .enable  (wd_en),
        .expired (wd_exp)
    );

    // Advancing events are tested before wd_exp so an event on the expiry cycle wins.
    always_comb begin
        st_d       = st_q;
        is_store_d = is_store_q;
        code_d     = code_q;
        ifu_rv     = 1'b0;
        lsu_rv     = 1'b0;
        lsu_w      = 1'b0;
        pc_w       = 1'b0;
        reg_w      = 1'b0;
        fin        = 1'b0;
        flt        = 1'b0;
        case (st_q)
            S_FETCH: begin
                ifu_rv = 1'b1;
                if (ifu_reqReady) st_d = S_FWAIT;
                else if (wd_exp) begin
                    st_d   = S_TRAP;
                    code_d = FAULT_FETCH;
                end
            end
            S_FWAIT: begin
                if (ifu_respValid) begin
                    if (inst_type == '1) begin
                        st_d   = S_TRAP;
                        code_d = FAULT_ILLEGAL;
                    end else begin
                        pc_w = 1'b1;
                        if (inst_type == TYPE_W'(INST_LOAD)) begin
                            is_store_d = 1'b0;
                            st_d       = S_MEM;
                        end else if (inst_type == TYPE_W'(INST_STORE)) begin
                            is_store_d = 1'b1;
                            st_d       = S_MEM;
                        end else begin
                            reg_w = 1'b1;
                            st_d  = S_EXEC;
                        end
                    end
                end else if (wd_exp) begin
                    st_d   = S_TRAP;
                    code_d = FAULT_FETCH;
                end
            end
            S_MEM: begin
                lsu_rv = 1'b1;
                lsu_w  = is_store_q;
                if (lsu_reqReady) st_d = S_MWAIT;
                else if (wd_exp) begin
                    st_d   = S_TRAP;
                    code_d = FAULT_MEM;
                end
            end
            S_MWAIT: begin
                if (lsu_respValid) begin
                    reg_w = !is_store_q;
                    st_d  = S_EXEC;
                end else if (wd_exp) begin
                    st_d   = S_TRAP;
                    code_d = FAULT_MEM;
                end
            end
            S_EXEC: begin
                fin  = 1'b1;
                st_d = S_FETCH;
            end
            S_TRAP: begin
                flt = 1'b1;
                if (fault_clear) begin
                    code_d = FAULT_NONE;
                    st_d   = S_FETCH;
                end
            end
            default: st_d = S_FETCH;
        endcase
    end

    // Mealy outputs are gated so nothing leaks out while reset is held low.
    assign ifu_reqValid = reset & ifu_rv;
    assign lsu_reqValid = reset & lsu_rv;
    assign lsu_wen      = reset & lsu_w;
    assign pc_wen       = reset & pc_w;
    assign reg_wen      = reset & reg_w;
    assign finished     = reset & fin;
    assign fault        = reset & flt;
    assign fault_code   = reset ? code_q : FAULT_NONE;
    assign state        = reset ? st_q : S_FETCH;

`ifdef CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] cyc_q, ret_q, stl_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cyc_q <= '0;
            ret_q <= '0;
            stl_q <= '0;
        end else begin
            cyc_q <= cyc_q + CNT_W'(1);
            if (fin) ret_q <= ret_q + CNT_W'(1);
            if ((st_q == S_FWAIT && !ifu_respValid) || (st_q == S_MWAIT && !lsu_respValid))
                stl_q <= stl_q + CNT_W'(1);
        end
    end

    assign cycle_cnt   = reset ? cyc_q : '0;
    assign instret_cnt = reset ? ret_q : '0;
    assign stall_cnt   = reset ? stl_q : '0;
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
    assign stall_cnt   = '0;
`endif

endmodule

// File: tb/tb_ctrl_fsm.sv
// Self-checking bench for ctrl_fsm: per-instruction transaction model versus observed pulses.
module tb_ctrl_fsm;
    import ctrl_pkg::*;

    localparam int MW = 4;
    localparam int CW = 16;
    localparam int TW = 4;
`ifdef CTRL_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clock, reset;
    logic          ifu_reqReady, ifu_respValid, lsu_reqReady, lsu_respValid, fault_clear;
    logic [TW-1:0] inst_type;
    logic          ifu_reqValid, lsu_reqValid, lsu_wen, pc_wen, reg_wen, finished, fault;
    logic [1:0]    fault_code;
    logic [2:0]    state;
    logic [CW-1:0] cycle_cnt, instret_cnt, stall_cnt;

    ctrl_fsm #(.MAX_WAIT(MW), .CNT_W(CW), .TYPE_W(TW)) dut (
        .clock(clock), .reset(reset),
        .ifu_reqReady(ifu_reqReady), .ifu_respValid(ifu_respValid),
        .lsu_reqReady(lsu_reqReady), .lsu_respValid(lsu_respValid),
        .inst_type(inst_type), .fault_clear(fault_clear),
        .ifu_reqValid(ifu_reqValid), .lsu_reqValid(lsu_reqValid), .lsu_wen(lsu_wen),
        .pc_wen(pc_wen), .reg_wen(reg_wen), .finished(finished), .fault(fault),
        .fault_code(fault_code), .state(state),
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt), .stall_cnt(stall_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc_m, instret_m, stall_m;

    always @(posedge clock or negedge reset)
        if (!reset) cyc_m <= 0;
        else        cyc_m <= cyc_m + 1;

    typedef struct packed {
        logic [1:0] code;
        logic [7:0] cycles;
        logic [7:0] ifu_cyc;
        logic [7:0] lsu_cyc;
        logic [3:0] pc;
        logic [3:0] rg;
        logic [3:0] fin;
        logic [3:0] flt;
        logic       wen;
        logic       clr_bad;
    } obs_t;

    // Whole-instruction outcome derived from phase delays: each phase advances when its
    // event arrives within MW cycles, otherwise the instruction traps.
    function automatic obs_t predict(input logic [3:0] it, input int frq, frs, mrq, mrs,
                                     output int stl);
        obs_t e;
        int   c;
        bit   dead, mem;
        e = '0; c = 0; stl = 0; dead = 1'b0;
        mem = (it == 4'h1) || (it == 4'h2);
        if (frq >= MW) begin e.ifu_cyc = 8'(MW); c = MW; e.code = 2'd1; dead = 1'b1; end
        else begin e.ifu_cyc = 8'(frq + 1); c = frq + 1; end
        if (!dead) begin
            if (frs >= MW) begin c += MW; stl += MW; e.code = 2'd1; dead = 1'b1; end
            else begin
                c += frs + 1; stl += frs;
                if (it == 4'hF) begin e.code = 2'd3; dead = 1'b1; end
                else e.pc = 4'd1;
            end
        end
        if (!dead && mem) begin
            e.wen = (it == 4'h2);
            if (mrq >= MW) begin e.lsu_cyc = 8'(MW); c += MW; e.code = 2'd2; dead = 1'b1; end
            else begin e.lsu_cyc = 8'(mrq + 1); c += mrq + 1; end
        end
        if (!dead && mem) begin
            if (mrs >= MW) begin c += MW; stl += MW; e.code = 2'd2; dead = 1'b1; end
            else begin c += mrs + 1; stl += mrs; e.rg = (it == 4'h1) ? 4'd1 : 4'd0; end
        end
        if (!dead) begin
            if (!mem) e.rg = 4'd1;
            c += 1;
            e.fin = 4'd1;
        end
        e.flt    = dead ? 4'd1 : 4'd0;
        e.cycles = 8'(c);
        return e;
    endfunction

    task automatic idle_inputs();
        {ifu_reqReady, ifu_respValid, lsu_reqReady, lsu_respValid, fault_clear} = '0;
        inst_type = '0;
    endtask

    // Drives one instruction from S_FETCH (called just after a posedge); inputs not
    // addressed to the current state get random noise that must be ignored.
    task automatic run_inst(input logic [3:0] it, input int frq, frs, mrq, mrs, output obs_t o);
        logic [2:0] st, prev;
        int k, n;
        o = '0; prev = 3'd7; k = 0; n = 0;
        forever begin
            @(negedge clock);
            st = state;
            k = (st == prev) ? k + 1 : 0;
            prev = st;
            if (st == S_TRAP) begin
                {ifu_reqReady, ifu_respValid, lsu_reqReady, lsu_respValid} = '0;
                fault_clear = 1'b1;
                #1;
                o.flt  = o.flt + 4'(fault);
                o.code = fault_code;
                @(posedge clock); #1;
                fault_clear = 1'b0;
                o.clr_bad = (state !== S_FETCH) || (fault_code !== 2'd0) || (fault !== 1'b0);
                break;
            end
            ifu_reqReady  = (st == S_FETCH) ? (k == frq) : 1'($urandom);
            ifu_respValid = (st == S_FWAIT) ? (k == frs) : 1'($urandom);
            inst_type     = (st == S_FWAIT) ? it : 4'($urandom);
            lsu_reqReady  = (st == S_MEM)   ? (k == mrq) : 1'($urandom);
            lsu_respValid = (st == S_MWAIT) ? (k == mrs) : 1'($urandom);
            fault_clear   = 1'($urandom);
            #1;
            o.cycles  = o.cycles + 8'd1;
            o.ifu_cyc = o.ifu_cyc + 8'(ifu_reqValid);
            o.lsu_cyc = o.lsu_cyc + 8'(lsu_reqValid);
            o.pc      = o.pc + 4'(pc_wen);
            o.rg      = o.rg + 4'(reg_wen);
            o.fin     = o.fin + 4'(finished);
            o.flt     = o.flt + 4'(fault);
            if (lsu_reqValid) o.wen = o.wen | lsu_wen;
            @(posedge clock);
            if (st == S_EXEC) begin #1; idle_inputs(); break; end
            n++;
            if (n > 200) begin
                errors++;
                $display("FAIL run_inst_timeout: state=%0d still busy after %0d cycles, need retire or trap", state, n);
                #1; idle_inputs();
                break;
            end
        end
    endtask

    task automatic do_inst(input logic [3:0] it, input int frq, frs, mrq, mrs,
                           output obs_t o, output obs_t e);
        int s;
        e = predict(it, frq, frs, mrq, mrs, s);
        run_inst(it, frq, frs, mrq, mrs, o);
        stall_m   += s;
        instret_m += int'(e.fin);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clock);
        @(negedge clock);
        ifu_reqReady = 1'b1; ifu_respValid = 1'b1; lsu_respValid = 1'b1; fault_clear = 1'b1;
        #1;
        checks++;
        if ({ifu_reqValid, lsu_reqValid, lsu_wen, pc_wen, reg_wen, finished, fault} !== 7'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, need 0000000",
                     {ifu_reqValid, lsu_reqValid, lsu_wen, pc_wen, reg_wen, finished, fault});
        end
        checks++;
        if (state !== S_FETCH || fault_code !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: state=%0d code=%0d, need 0/0", state, fault_code);
        end
        checks++;
        if ({cycle_cnt, instret_cnt, stall_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_counters: got %h/%h/%h, need 0", cycle_cnt, instret_cnt, stall_cnt);
        end
        @(posedge clock); #1;
        idle_inputs();
        reset = 1'b1;
        instret_m = 0; stall_m = 0;
        #1;
        checks++;
        if (ifu_reqValid !== 1'b1 || state !== S_FETCH) begin
            errors++;
            $display("FAIL reset_release: ifu_reqValid=%b state=%0d, need 1/0", ifu_reqValid, state);
        end
    endtask

    task automatic check_inst(input string name, input obs_t o, input obs_t e);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL %s: got %h, need %h", name, o, e);
        end
    endtask

    task automatic test_alu();
        obs_t o, e;
        do_inst(4'h0, 0, 0, 0, 0, o, e);
        check_inst("alu_fast", o, e);
        checks++;
        if (state !== S_FETCH) begin
            errors++;
            $display("FAIL alu_return: state=%0d, need %0d", state, S_FETCH);
        end
    endtask

    task automatic test_load();
        obs_t o, e;
        do_inst(4'h1, 1, 0, 3, 2, o, e);
        check_inst("load_stall", o, e);
    endtask

    task automatic test_store();
        obs_t o, e;
        do_inst(4'h2, 0, 2, 1, 1, o, e);
        check_inst("store", o, e);
        checks++;
        if (instret_cnt !== (PERF ? CW'(instret_m) : CW'(0))) begin
            errors++;
            $display("FAIL store_instret: got %0d, need %0d", instret_cnt, PERF ? instret_m : 0);
        end
    endtask

    task automatic test_timeouts();
        obs_t o, e;
        do_inst(4'h0, 0, 4, 0, 0, o, e);
        check_inst("fwait_timeout", o, e);
        do_inst(4'h3, 4, 0, 0, 0, o, e);
        check_inst("fetch_timeout", o, e);
        do_inst(4'h1, 0, 0, 0, 4, o, e);
        check_inst("mwait_timeout", o, e);
    endtask

    task automatic test_expiry_edge();
        obs_t o, e;
        do_inst(4'h1, 0, 0, 0, MW - 1, o, e);
        check_inst("mwait_event_on_expiry", o, e);
        do_inst(4'h2, MW - 1, MW - 1, MW - 1, 0, o, e);
        check_inst("all_events_on_expiry", o, e);
    endtask

    task automatic test_illegal();
        obs_t o, e;
        do_inst(4'hF, 0, 1, 0, 0, o, e);
        check_inst("illegal", o, e);
    endtask

    task automatic test_random();
        obs_t o, e;
        logic [3:0] it;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0: it = 4'h1;
                1: it = 4'h2;
                2: it = 4'hF;
                3: it = 4'h0;
                default: it = 4'($urandom);
            endcase
            do_inst(it, $urandom_range(0, MW), $urandom_range(0, MW),
                    $urandom_range(0, MW), $urandom_range(0, MW), o, e);
            check_inst("random_inst", o, e);
        end
        checks++;
        if ({cycle_cnt, instret_cnt, stall_cnt} !==
            (PERF ? {CW'(cyc_m), CW'(instret_m), CW'(stall_m)} : {3*CW{1'b0}})) begin
            errors++;
            $display("FAIL random_perf: got %0d/%0d/%0d, need %0d/%0d/%0d (perf=%0d)",
                     cycle_cnt, instret_cnt, stall_cnt, cyc_m, instret_m, stall_m, PERF);
        end
    endtask

    task automatic test_reset_mid();
        obs_t o, e;
        @(negedge clock); ifu_reqReady = 1'b1;
        @(negedge clock); ifu_reqReady = 1'b0; ifu_respValid = 1'b1; inst_type = 4'h1;
        @(negedge clock); ifu_respValid = 1'b0; lsu_reqReady = 1'b1;
        @(negedge clock); lsu_reqReady = 1'b0;
        checks++;
        if (state !== S_MWAIT) begin
            errors++;
            $display("FAIL reset_mid_setup: state=%0d, need %0d", state, S_MWAIT);
        end
        ifu_reqReady = 1'b1; lsu_respValid = 1'b1;
        reset = 1'b0;
        #1;
        checks++;
        if ({ifu_reqValid, lsu_reqValid, lsu_wen, pc_wen, reg_wen, finished, fault, fault_code,
             state, cycle_cnt, instret_cnt, stall_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: reqV=%b lsuV=%b reg=%b state=%0d cnt=%0d/%0d/%0d, need all 0",
                     ifu_reqValid, lsu_reqValid, reg_wen, state, cycle_cnt, instret_cnt, stall_cnt);
        end
        @(posedge clock); #1;
        idle_inputs();
        reset = 1'b1;
        instret_m = 0; stall_m = 0;
        do_inst(4'h0, 0, 0, 0, 0, o, e);
        check_inst("after_reset_mid", o, e);
        checks++;
        if (instret_cnt !== (PERF ? CW'(1) : CW'(0))) begin
            errors++;
            $display("FAIL reset_mid_instret: got %0d, need %0d", instret_cnt, PERF ? 1 : 0);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_timeouts();
        test_expiry_edge();
        test_illegal();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not reach its summary");
        $fatal(1);
    end

endmodule
